lcd_cmd_seq: RTL and testbench
==============================

# lcd_cmd_seq

Command sequencer placed directly upstream of the LCD image controller. It fetches 4-bit command codes from a command ROM and issues them one at a time on the controller's `cmd`/`cmd_valid` port, honouring `busy`. It stops after the controller completes a Write command, which is signalled by `done`. It also filters illegal codes, counts issued and skipped commands, and runs a watchdog against a controller that never releases `busy`.

## Interface
- `CROM_AW`, 6: command ROM address width; the ROM holds 2^CROM_AW entries.
- `TIMEOUT`, 1024: maximum cycles spent in ISSUE+WAIT for one command before an error is flagged.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `CROM_rd` out 1: command ROM read enable; registered.
- `CROM_A` out CROM_AW: command ROM address; registered.
- `CROM_Q` in 4: ROM data, valid the cycle after `CROM_rd`=1.
- `cmd` out 4: command code to the controller; registered.
- `cmd_valid` out 1: command strobe; combinational, equal to (state==ISSUE && !busy).
- `busy` in 1: controller busy.
- `done` in 1: controller Write-complete pulse.
- `seq_busy` out 1: high whenever state != IDLE.
- `seq_done` out 1: one-cycle pulse on entering END.
- `seq_err` out 1: sticky error flag; cleared by an accepted `start`.
- `issued_cnt` out 8: commands accepted by the controller; saturates at 255.
- `skip_cnt` out 8: illegal codes skipped; saturates at 255.

## Operation
States: IDLE, FETCH, DECODE, ISSUE, ACK, WAIT, END.
- **IDLE**
  - On `start`=1: ptr←0, counters←0, `seq_err`←0, go to FETCH.
- **FETCH**
  - `CROM_A`←ptr, `CROM_rd`←1 (high for exactly one cycle), go to DECODE.
- **DECODE**
  - `CROM_Q` is valid in this cycle.
  - Code 0–11 (legal): `cmd`←code, go to ISSUE.
  - Code 12–15 (illegal): increment `skip_cnt`, then advance.
- **Advance**
  - If ptr == 2^CROM_AW−1: `seq_err`←1, go to END.
  - Otherwise ptr←ptr+1, go to FETCH.
- **ISSUE**
  - `cmd_valid`=1 only in cycles where `busy`=0; the controller accepts in that same cycle.
  - When `cmd_valid`=1, go to ACK.
  - While `busy`=1, remain in ISSUE. This wait includes the controller's post-reset image-load period.
- **ACK**
  - One cycle; the controller now reports `busy`=1.
  - If `done`=1 in this cycle, set the done_seen flag.
  - Go to WAIT.
- **WAIT**
  - A `done` pulse in this state sets done_seen.
  - When `busy`=0: increment `issued_cnt`.
    - If `cmd`==0 (Write): go to END. If done_seen=0, also set `seq_err`←1.
    - Otherwise: advance (same rules as above).
- **END**
  - Pulse `seq_done`, clear done_seen, go to IDLE.
- **Watchdog**
  - Counter cleared on entry to ISSUE; increments in ISSUE, ACK and WAIT.
  - When it reaches TIMEOUT: `seq_err`←1, go to END. `cmd_valid` must not assert in that cycle.
- **Counters** are 8-bit and saturating; they hold their values in IDLE until the next `start`.
- **Ignored inputs:** `start` outside IDLE; `done` outside ACK/WAIT.

## Timing
- **Reset values**
  - `CROM_rd`=0, `CROM_A`=0, `cmd`=0, `seq_done`=0, `seq_err`=0, `issued_cnt`=0, `skip_cnt`=0.
  - `cmd_valid`=0 and `seq_busy`=0, because state=IDLE.
- **Reset mid-operation**
  - Returns to IDLE immediately and clears all counters and flags.
  - `cmd_valid` drops asynchronously with the state.
- **Latency, `start` to first `cmd_valid`** with `busy`=0: 3 cycles (FETCH, DECODE, ISSUE).
- **Per legal non-Write command** with a 1-cycle controller operation: FETCH, DECODE, ISSUE, ACK, WAIT = 5 cycles minimum.
- **Illegal code cost:** 2 cycles (FETCH, DECODE); no `cmd_valid` is issued.
- **`cmd` stability:** `cmd` is stable from DECODE exit until the next DECODE, so it is always stable while `cmd_valid`=1.
- **Busy and reset in the same cycle:** if `busy` rises in the same cycle that `reset` deasserts, the sequencer still waits in ISSUE; no command is lost.

## Test plan
- **Basic run.** ROM = {1,4,5,0}. Controller `busy` released after the 64-cycle load.
  - Four `cmd_valid` pulses with `cmd` = 1, 4, 5, 0.
  - `issued_cnt`=4, `skip_cnt`=0.
  - `seq_done` pulses once after `done`; `seq_err`=0.
- **Illegal filtering.** ROM = {13,2,15,0}.
  - `cmd_valid` only for codes 2 and 0.
  - `skip_cnt`=2, `issued_cnt`=2, `seq_err`=0.
- **Busy stall.** Hold `busy`=1 for 40 cycles after `start`.
  - `cmd_valid` stays 0 throughout.
  - It asserts in the first cycle `busy`=0.
  - `cmd` is unchanged across the stall.
- **Watchdog.** TIMEOUT=16; `busy` stuck at 1 after the first accept.
  - `seq_err`=1 and `seq_done` pulses exactly 16 cycles after ISSUE entry.
  - No further `cmd_valid`.
- **End of ROM.** CROM_AW=2, ROM = {1,1,1,1}.
  - After 4 issues, `seq_done` pulses with `seq_err`=1.
  - `CROM_A` never exceeds 3.
- **Reset mid-run.** Assert `reset` during WAIT of the 2nd command.
  - All outputs return to reset values in the same cycle.
  - A subsequent `start` restarts from `CROM_A`=0.

Source files
------------

// File: rtl/lcd_cmd_seq_if.sv
// Sequencer <-> command ROM and sequencer <-> LCD image controller signals.
// The master side is the sequencer; the slave side is the ROM + controller.
interface lcd_cmd_seq_if #(
  parameter int CROM_AW = 6
);
  logic               CROM_rd;
  logic [CROM_AW-1:0] CROM_A;
  logic [3:0]         CROM_Q;
  logic [3:0]         cmd;
  logic               cmd_valid;
  logic               busy;
  logic               done;

  modport master (
    output CROM_rd, CROM_A, cmd, cmd_valid,
    input  CROM_Q, busy, done
  );

  modport slave (
    input  CROM_rd, CROM_A, cmd, cmd_valid,
    output CROM_Q, busy, done
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// Command sequencer: walks the command ROM, drops illegal codes, hands legal
// codes to the LCD controller one at a time and stops after a completed Write.
// A watchdog bounds the time spent on any one command.
module lcd_cmd_seq #(
  parameter int CROM_AW = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  lcd_cmd_seq_if.master     bus,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [7:0]        issued_cnt,
  output logic [7:0]        skip_cnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CROM_AW-1:0] PTR_LAST = {CROM_AW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_ACK, S_WAIT, S_END
  } state_t;

  state_t             state_reg, state_next;
  logic [CROM_AW-1:0] ptr_reg, ptr_next;
  logic               crom_rd_reg, crom_rd_next;
  logic [CROM_AW-1:0] crom_a_reg, crom_a_next;
  logic [3:0]         cmd_reg, cmd_next;
  logic               seq_done_reg, seq_done_next;
  logic               seq_err_reg, seq_err_next;
  logic [7:0]         issued_reg, issued_next;
  logic [7:0]         skip_reg, skip_next;
  logic [WD_W-1:0]    wd_reg, wd_next;
  logic               done_seen_reg, done_seen_next;
  logic               cmd_valid_c;
  logic               advance;
  logic               wd_active;
  logic               wd_expired;

  // State and output registers; everything returns to idle values on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      crom_rd_reg   <= 1'b0;
      crom_a_reg    <= '0;
      cmd_reg       <= 4'd0;
      seq_done_reg  <= 1'b0;
      seq_err_reg   <= 1'b0;
      issued_reg    <= 8'd0;
      skip_reg      <= 8'd0;
      wd_reg        <= '0;
      done_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      crom_rd_reg   <= crom_rd_next;
      crom_a_reg    <= crom_a_next;
      cmd_reg       <= cmd_next;
      seq_done_reg  <= seq_done_next;
      seq_err_reg   <= seq_err_next;
      issued_reg    <= issued_next;
      skip_reg      <= skip_next;
      wd_reg        <= wd_next;
      done_seen_reg <= done_seen_next;
    end
  end

  // Next-state logic, command strobe and counter/flag updates.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    crom_rd_next   = 1'b0;
    crom_a_next    = crom_a_reg;
    cmd_next       = cmd_reg;
    seq_done_next  = 1'b0;
    seq_err_next   = seq_err_reg;
    issued_next    = issued_reg;
    skip_next      = skip_reg;
    wd_next        = wd_reg;
    done_seen_next = done_seen_reg;
    cmd_valid_c    = 1'b0;
    advance        = 1'b0;

    wd_active  = (state_reg == S_ISSUE) || (state_reg == S_ACK) || (state_reg == S_WAIT);
    wd_expired = wd_active && (wd_reg == WD_LAST);
    if (wd_active) begin
      wd_next = wd_reg + WD_W'(1);
    end

    if (wd_expired) begin
      // Expiry wins over everything, including a strobe in ISSUE.
      seq_err_next = 1'b1;
      state_next   = S_END;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            ptr_next     = '0;
            issued_next  = 8'd0;
            skip_next    = 8'd0;
            seq_err_next = 1'b0;
            state_next   = S_FETCH;
          end
        end
        S_FETCH: begin
          state_next = S_DECODE;
        end
        S_DECODE: begin
          if (bus.CROM_Q <= 4'd11) begin
            cmd_next   = bus.CROM_Q;
            wd_next    = '0;
            state_next = S_ISSUE;
          end else begin
            skip_next = (skip_reg == 8'hFF) ? skip_reg : skip_reg + 8'd1;
            advance   = 1'b1;
          end
        end
        S_ISSUE: begin
          if (!bus.busy) begin
            cmd_valid_c = 1'b1;
            state_next  = S_ACK;
          end
        end
        S_ACK: begin
          if (bus.done) begin
            done_seen_next = 1'b1;
          end
          state_next = S_WAIT;
        end
        S_WAIT: begin
          if (bus.done) begin
            done_seen_next = 1'b1;
          end
          if (!bus.busy) begin
            issued_next = (issued_reg == 8'hFF) ? issued_reg : issued_reg + 8'd1;
            if (cmd_reg == 4'd0) begin
              // A Write that finished without a done pulse is an error.
              if (!(done_seen_reg || bus.done)) begin
                seq_err_next = 1'b1;
              end
              state_next = S_END;
            end else begin
              advance = 1'b1;
            end
          end
        end
        S_END: begin
          done_seen_next = 1'b0;
          state_next     = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end

    // Step to the next ROM entry, or stop with an error at the last one.
    if (advance) begin
      if (ptr_reg == PTR_LAST) begin
        seq_err_next = 1'b1;
        state_next   = S_END;
      end else begin
        ptr_next   = ptr_reg + CROM_AW'(1);
        state_next = S_FETCH;
      end
    end

    // ROM read is presented during FETCH so data lands in DECODE.
    if (state_next == S_FETCH) begin
      crom_rd_next = 1'b1;
      crom_a_next  = ptr_next;
    end

    if ((state_next == S_END) && (state_reg != S_END)) begin
      seq_done_next = 1'b1;
    end
  end

  assign bus.CROM_rd   = crom_rd_reg;
  assign bus.CROM_A    = crom_a_reg;
  assign bus.cmd       = cmd_reg;
  assign bus.cmd_valid = cmd_valid_c;
  assign seq_busy      = (state_reg != S_IDLE);
  assign seq_done      = seq_done_reg;
  assign seq_err       = seq_err_reg;
  assign issued_cnt    = issued_reg;
  assign skip_cnt      = skip_reg;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq. Instance 0 uses the default geometry
// (64-entry ROM, long watchdog); instance 1 uses a 4-entry ROM and a
// 16-cycle watchdog. Each instance has a ROM model, a small controller
// model and a monitor that logs accepted commands.
module tb_lcd_cmd_seq;

  logic clk;
  logic reset;
  logic clr_mon;

  logic       start_i    [2];
  logic       force_busy [2];
  logic       stuck_arm  [2];
  logic       no_done    [2];
  logic [3:0] op_len     [2];
  logic [3:0] rom        [2][64];

  wire        cv_o       [2];
  wire        crom_rd_o  [2];
  wire [5:0]  crom_a_o   [2];
  wire [3:0]  cmd_o      [2];
  logic       seq_busy_o [2];
  logic       seq_done_o [2];
  logic       seq_err_o  [2];
  logic [7:0] issued_o   [2];
  logic [7:0] skip_o     [2];

  wire [31:0] mon_log   [2];
  wire [31:0] mon_ncv   [2];
  wire [31:0] mon_ndone [2];
  wire [31:0] mon_nrd   [2];
  wire [31:0] mon_maxa  [2];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int AW = (gi == 0) ? 6 : 2;
    localparam int TO = (gi == 0) ? 1024 : 16;

    lcd_cmd_seq_if #(.CROM_AW(AW)) bus ();

    logic [3:0]  q_reg;
    logic [3:0]  op_reg;
    logic        wr_reg;
    logic        stuck_reg;
    logic [31:0] log_reg;
    logic [31:0] ncv_reg;
    logic [31:0] ndone_reg;
    logic [31:0] nrd_reg;
    logic [31:0] maxa_reg;

    lcd_cmd_seq #(.CROM_AW(AW), .TIMEOUT(TO)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_i[gi]),
      .bus        (bus),
      .seq_busy   (seq_busy_o[gi]),
      .seq_done   (seq_done_o[gi]),
      .seq_err    (seq_err_o[gi]),
      .issued_cnt (issued_o[gi]),
      .skip_cnt   (skip_o[gi])
    );

    // Synchronous command ROM
    always @(posedge clk) begin
      if (bus.CROM_rd) q_reg <= rom[gi][6'(bus.CROM_A)];
    end

    // Controller: busy for op_len cycles after an accept, done on the last
    // busy cycle of a Write; stuck_arm freezes busy after the next accept.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        op_reg    <= 4'd0;
        wr_reg    <= 1'b0;
        stuck_reg <= 1'b0;
      end else begin
        if (!stuck_arm[gi]) stuck_reg <= 1'b0;
        if (bus.cmd_valid) begin
          op_reg <= op_len[gi];
          wr_reg <= (bus.cmd == 4'd0);
          if (stuck_arm[gi]) stuck_reg <= 1'b1;
        end else if (op_reg != 4'd0) begin
          op_reg <= op_reg - 4'd1;
        end
      end
    end

    assign bus.CROM_Q = q_reg;
    assign bus.busy   = force_busy[gi] | stuck_reg | (op_reg != 4'd0);
    assign bus.done   = (op_reg == 4'd1) && wr_reg && !no_done[gi];

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
      if (clr_mon) begin
        log_reg   <= 32'd0;
        ncv_reg   <= 32'd0;
        ndone_reg <= 32'd0;
        nrd_reg   <= 32'd0;
        maxa_reg  <= 32'd0;
      end else begin
        if (bus.cmd_valid) begin
          log_reg <= {log_reg[27:0], bus.cmd};
          ncv_reg <= ncv_reg + 32'd1;
          $display("  inst%0d cmd_valid cmd=%0d t=%0t", gi, bus.cmd, $time);
        end
        if (seq_done_o[gi]) ndone_reg <= ndone_reg + 32'd1;
        if (bus.CROM_rd) begin
          nrd_reg <= nrd_reg + 32'd1;
          if (32'(bus.CROM_A) > maxa_reg) maxa_reg <= 32'(bus.CROM_A);
        end
      end
    end

    assign cv_o[gi]      = bus.cmd_valid;
    assign crom_rd_o[gi] = bus.CROM_rd;
    assign crom_a_o[gi]  = 6'(bus.CROM_A);
    assign cmd_o[gi]     = bus.cmd;
    assign mon_log[gi]   = log_reg;
    assign mon_ncv[gi]   = ncv_reg;
    assign mon_ndone[gi] = ndone_reg;
    assign mon_nrd[gi]   = nrd_reg;
    assign mon_maxa[gi]  = maxa_reg;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_rom(input int i, input logic [15:0] w);
    for (int k = 0; k < 64; k++) rom[i][k] = 4'd0;
    rom[i][0] = w[15:12];
    rom[i][1] = w[11:8];
    rom[i][2] = w[7:4];
    rom[i][3] = w[3:0];
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge clk);
    #1;
    clr_mon = 1'b0;
  endtask

  task automatic run_start(input int i);
    start_i[i] = 1'b1;
    tick(1);
    start_i[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, input string tag);
    int k;
    k = 0;
    while (seq_busy_o[i] && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_idle"}, 32'(seq_busy_o[i]), 32'd0);
  endtask

  initial begin
    int k;
    int n;
    reset   = 1'b1;
    clr_mon = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_i[i]    = 1'b0;
      force_busy[i] = 1'b0;
      stuck_arm[i]  = 1'b0;
      no_done[i]    = 1'b0;
      op_len[i]     = 4'd1;
    end
    load_rom(0, 16'h1450);
    load_rom(1, 16'h1111);
    force_busy[0] = 1'b1;
    tick(3);

    // Reset values
    check("rst_crom_rd",   32'(crom_rd_o[0]),  32'd0);
    check("rst_crom_a",    32'(crom_a_o[0]),   32'd0);
    check("rst_cmd",       32'(cmd_o[0]),      32'd0);
    check("rst_cmd_valid", 32'(cv_o[0]),       32'd0);
    check("rst_seq_busy",  32'(seq_busy_o[0]), 32'd0);
    check("rst_seq_done",  32'(seq_done_o[0]), 32'd0);
    check("rst_seq_err",   32'(seq_err_o[0]),  32'd0);
    check("rst_issued",    32'(issued_o[0]),   32'd0);
    check("rst_skip",      32'(skip_o[0]),     32'd0);
    reset   = 1'b0;
    clr_mon = 1'b0;

    // Basic run behind a 64-cycle controller load
    run_start(0);
    tick(62);
    force_busy[0] = 1'b0;
    wait_idle(0, 400, "basic");
    check("basic_ncv",    mon_ncv[0],          32'd4);
    check("basic_log",    mon_log[0],          32'h0000_1450);
    check("basic_issued", 32'(issued_o[0]),    32'd4);
    check("basic_skip",   32'(skip_o[0]),      32'd0);
    check("basic_ndone",  mon_ndone[0],        32'd1);
    check("basic_err",    32'(seq_err_o[0]),   32'd0);

    // Start-to-strobe latency: FETCH, DECODE, ISSUE
    load_rom(0, 16'h7000);
    clear_mon();
    run_start(0);
    check("lat_fetch_rd", 32'(crom_rd_o[0]), 32'd1);
    check("lat_fetch_cv", 32'(cv_o[0]),      32'd0);
    tick(1);
    check("lat_decode_cv", 32'(cv_o[0]), 32'd0);
    tick(1);
    check("lat_issue_cv",  32'(cv_o[0]),  32'd1);
    check("lat_issue_cmd", 32'(cmd_o[0]), 32'd7);
    wait_idle(0, 100, "lat");
    check("lat_issued", 32'(issued_o[0]), 32'd2);

    // Write that completes without a done pulse
    load_rom(0, 16'h0000);
    no_done[0] = 1'b1;
    clear_mon();
    run_start(0);
    wait_idle(0, 100, "nodone");
    check("nodone_err",    32'(seq_err_o[0]), 32'd1);
    check("nodone_issued", 32'(issued_o[0]),  32'd1);
    check("nodone_ndone",  mon_ndone[0],      32'd1);
    no_done[0] = 1'b0;

    // Illegal code filtering; start also clears the sticky error
    load_rom(0, 16'hD2F0);
    clear_mon();
    run_start(0);
    check("illegal_err_cleared", 32'(seq_err_o[0]), 32'd0);
    wait_idle(0, 100, "illegal");
    check("illegal_ncv",    mon_ncv[0],        32'd2);
    check("illegal_log",    mon_log[0],        32'h0000_0020);
    check("illegal_skip",   32'(skip_o[0]),    32'd2);
    check("illegal_issued", 32'(issued_o[0]),  32'd2);
    check("illegal_err",    32'(seq_err_o[0]), 32'd0);

    // Busy stall for 40 cycles after start
    load_rom(0, 16'h3000);
    force_busy[0] = 1'b1;
    clear_mon();
    run_start(0);
    tick(39);
    check("stall_no_cv",     mon_ncv[0],      32'd0);
    check("stall_cmd_held",  32'(cmd_o[0]),   32'd3);
    force_busy[0] = 1'b0;
    #1;
    check("stall_cv_release", 32'(cv_o[0]),  32'd1);
    check("stall_cmd_release", 32'(cmd_o[0]), 32'd3);
    wait_idle(0, 100, "stall");
    check("stall_ncv", mon_ncv[0], 32'd2);
    check("stall_log", mon_log[0], 32'h0000_0030);

    // Reset during WAIT of the second command
    load_rom(0, 16'h1200);
    op_len[0] = 4'd5;
    clear_mon();
    run_start(0);
    k = 0;
    while (mon_ncv[0] < 32'd2 && k < 100) begin
      tick(1);
      k++;
    end
    check("rmr_second_accept", mon_ncv[0], 32'd2);
    tick(2);
    check("rmr_busy_before",   32'(seq_busy_o[0]), 32'd1);
    check("rmr_issued_before", 32'(issued_o[0]),   32'd1);
    check("rmr_addr_before",   32'(crom_a_o[0]),   32'd1);
    reset = 1'b1;
    #1;
    check("rmr_cv",       32'(cv_o[0]),       32'd0);
    check("rmr_seq_busy", 32'(seq_busy_o[0]), 32'd0);
    check("rmr_issued",   32'(issued_o[0]),   32'd0);
    check("rmr_crom_a",   32'(crom_a_o[0]),   32'd0);
    check("rmr_cmd",      32'(cmd_o[0]),      32'd0);
    check("rmr_crom_rd",  32'(crom_rd_o[0]),  32'd0);
    tick(1);
    reset = 1'b0;
    op_len[0] = 4'd1;
    clear_mon();
    run_start(0);
    check("rmr_restart_addr", 32'(crom_a_o[0]), 32'd0);
    wait_idle(0, 100, "rmr");
    check("rmr_log",    mon_log[0],       32'h0000_0120);
    check("rmr_issued_after", 32'(issued_o[0]), 32'd3);

    // Watchdog on instance 1: busy sticks after the first accept
    load_rom(1, 16'h1200);
    stuck_arm[1] = 1'b1;
    clear_mon();
    run_start(1);
    k = 0;
    while (!cv_o[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wd_first_cv", 32'(cv_o[1]), 32'd1);
    n = 0;
    while (!seq_done_o[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wd_cycles", 32'(n),             32'd16);
    check("wd_err",    32'(seq_err_o[1]),  32'd1);
    tick(5);
    check("wd_ncv",    mon_ncv[1],         32'd1);
    check("wd_idle",   32'(seq_busy_o[1]), 32'd0);
    stuck_arm[1] = 1'b0;
    tick(2);

    // End of ROM on instance 1
    load_rom(1, 16'h1111);
    clear_mon();
    run_start(1);
    check("eor_err_cleared", 32'(seq_err_o[1]), 32'd0);
    wait_idle(1, 200, "eor");
    check("eor_ncv",    mon_ncv[1],       32'd4);
    check("eor_log",    mon_log[1],       32'h0000_1111);
    check("eor_issued", 32'(issued_o[1]), 32'd4);
    check("eor_err",    32'(seq_err_o[1]), 32'd1);
    check("eor_ndone",  mon_ndone[1],     32'd1);
    check("eor_nrd",    mon_nrd[1],       32'd4);
    check("eor_max_a",  mon_maxa[1],      32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
